// File: rtl/tlb_assoc.sv
// Fully-associative translation buffer with round-robin refill, flush, privilege check
// and a saturating miss counter. Misses are resolved through a req/ack page-table walk.
module tlb_assoc #(
    parameter int VA_WIDTH    = 32,
    parameter int PA_WIDTH    = 20,
    parameter int PAGE_BITS   = 12,
    parameter int NUM_ENTRIES = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [VA_WIDTH-1:0]           req_vaddr,
    input  logic                          req_user,
    output logic                          resp_valid,
    output logic [PA_WIDTH-1:0]           resp_paddr,
    output logic                          resp_hit,
    output logic                          resp_fault,
    output logic                          walk_req,
    output logic [VA_WIDTH-PAGE_BITS-1:0] walk_vpn,
    input  logic                          walk_ack,
    input  logic [PA_WIDTH-PAGE_BITS-1:0] walk_ppn,
    input  logic                          walk_super,
    input  logic                          walk_fault,
    input  logic                          flush,
    output logic [CNT_WIDTH-1:0]          miss_count,
    output logic                          dbg_state
);
    localparam int VPN_W = VA_WIDTH - PAGE_BITS;
    localparam int PPN_W = PA_WIDTH - PAGE_BITS;
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    typedef enum logic {IDLE = 1'b0, WALK = 1'b1} state_t;
    state_t state, state_next;

    logic [NUM_ENTRIES-1:0] ent_valid;
    logic [NUM_ENTRIES-1:0] ent_super;
    logic [VPN_W-1:0]       ent_vpn [NUM_ENTRIES];
    logic [PPN_W-1:0]       ent_ppn [NUM_ENTRIES];
    logic [IDX_W-1:0]       rr_ptr;

    logic [PAGE_BITS-1:0]   lat_off;
    logic                   lat_user;

    logic [VPN_W-1:0]       req_vpn;
    logic                   accept, take_ack, fill;
    logic                   hit, hit_super;
    logic [PPN_W-1:0]       hit_ppn;
    logic [IDX_W-1:0]       vic_idx;
    logic                   vic_free;

    // Handshake: a request transfers on a cycle where req_valid && req_ready; req_ready is
    // high exactly while the FSM is IDLE. walk_req holds until walk_ack is seen in WALK.
    assign req_ready = (state == IDLE);
    assign dbg_state = (state == WALK);
    assign req_vpn   = req_vaddr[VA_WIDTH-1:PAGE_BITS];
    assign accept    = req_valid && (state == IDLE);
    assign take_ack  = walk_ack && (state == WALK);
    assign fill      = take_ack && !walk_fault && !flush;

    // A flush in the accept cycle hides every entry from the lookup.
    always_comb begin
        hit       = 1'b0;
        hit_super = 1'b0;
        hit_ppn   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent_valid[i] && !flush && ent_vpn[i] == req_vpn) begin
                hit       = 1'b1;
                hit_super = ent_super[i];
                hit_ppn   = ent_ppn[i];
            end
        end
    end

    always_comb begin
        vic_idx  = rr_ptr;
        vic_free = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                vic_idx  = IDX_W'(i);
                vic_free = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && !hit) state_next = WALK;
            WALK:    if (walk_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            ent_valid <= '0;
        end else if (fill) begin
            ent_valid[vic_idx] <= 1'b1;
            ent_super[vic_idx] <= walk_super;
            ent_vpn[vic_idx]   <= walk_vpn;
            ent_ppn[vic_idx]   <= walk_ppn;
            if (!vic_free) rr_ptr <= rr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_fault <= 1'b0;
            resp_paddr <= '0;
            walk_req   <= 1'b0;
            walk_vpn   <= '0;
            miss_count <= '0;
            lat_off    <= '0;
            lat_user   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_fault <= 1'b0;
            resp_paddr <= '0;
            if (accept && hit) begin
                resp_valid <= 1'b1;
                resp_hit   <= 1'b1;
                resp_fault <= req_user & hit_super;
                resp_paddr <= {hit_ppn, req_vaddr[PAGE_BITS-1:0]};
            end else if (accept) begin
                walk_req <= 1'b1;
                walk_vpn <= req_vpn;
                lat_off  <= req_vaddr[PAGE_BITS-1:0];
                lat_user <= req_user;
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end
            if (take_ack) begin
                walk_req   <= 1'b0;
                walk_vpn   <= '0;
                resp_valid <= 1'b1;
                resp_fault <= walk_fault | (lat_user & walk_super);
                resp_paddr <= walk_fault ? '0 : {walk_ppn, lat_off};
            end
        end
    end
endmodule
